tdc_meas_ctrl: RTL and testbench

Measurement sequencer for the TDC fine-time path. It arms on request and captures the 32-bit phase vector at the start hit and at the stop hit, while counting coarse clock cycles between them. It then time-multiplexes the single thermometer decoder (32-bit phase in, 5-bit fine code out, combinational) over both captured vectors. Finally it combines coarse and fine codes into one interval result, presented on a valid/ready interface.

---
 rtl/tdc_meas_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: measurement sequencer for the TDC fine-time path.
// Arms on request, captures the phase vector at the start and stop hits and
// counts coarse cycles in between. It then shares one external thermometer
// decoder across both captured vectors and combines coarse and fine codes
// into a single interval result on a valid/ready interface.
//
// Optional feature macro: TDC_BUBBLE_CHK_EN
//   Defined   - each vector presented to the decoder is checked for a single
//               cyclic run of 16 ones; an illegal vector forces res_err=1 and
//               res_time=0 for that measurement.
//   Undefined - no check logic; res_err is tied low.
module tdc_meas_ctrl #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             start_hit,
  input  logic             stop_hit,
  input  logic [31:0]      phase,
  output logic [31:0]      dec_in,
  input  logic [4:0]       dec_out,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W+4:0] res_time,
  output logic             res_timeout,
  output logic             res_err
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_RUN        = 3'd2,
    S_DEC_A      = 3'd3,
    S_DEC_B      = 3'd4,
    S_CALC       = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  // Last coarse value at which a missing stop still counts as in range.
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
  // Timeout result marker: every result bit set.
  localparam logic [CNT_W+4:0] RES_ALL_ONES = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   coarse_q, coarse_d;
  logic [31:0]        ph_start_q, ph_start_d;
  logic [31:0]        ph_stop_q, ph_stop_d;
  logic [4:0]         fine_a_q, fine_a_d;
  logic [4:0]         fine_b_q, fine_b_d;
  logic [CNT_W+4:0]   res_time_q, res_time_d;
  logic               res_timeout_q, res_timeout_d;

  // coarse*32 + fine_b - fine_a, one extra bit so the coarse=0 underflow
  // case is visible as a negative number.
  logic signed [CNT_W+5:0] calc_s;

`ifdef TDC_BUBBLE_CHK_EN
  logic        err_q, err_d;
  logic        res_err_q, res_err_d;
  logic [31:0] edge_vec;
  logic        dec_legal;

  // A 0->1 or 1->0 transition between each bit and its cyclic lower neighbour.
  for (genvar gi = 0; gi < 32; gi++) begin : g_edge
    assign edge_vec[gi] = dec_in[gi] ^ dec_in[(gi + 31) % 32];
  end

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] sum;
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + 6'(v[i]);
    end
    return sum;
  endfunction

  // Legal: exactly 16 ones forming one cyclic run (exactly two edges).
  always_comb begin
    dec_legal = (popcnt32(dec_in) == 6'd16) && (popcnt32(edge_vec) == 6'd2);
  end
`endif

  // Decoder input mux: only the decode states present a captured vector.
  always_comb begin
    dec_in = 32'h0;
    case (state_q)
      S_DEC_A: dec_in = ph_start_q;
      S_DEC_B: dec_in = ph_stop_q;
      default: dec_in = 32'h0;
    endcase
  end

  // State and datapath registers; reset returns everything to zero / IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      coarse_q      <= '0;
      ph_start_q    <= '0;
      ph_stop_q     <= '0;
      fine_a_q      <= '0;
      fine_b_q      <= '0;
      res_time_q    <= '0;
      res_timeout_q <= 1'b0;
`ifdef TDC_BUBBLE_CHK_EN
      err_q         <= 1'b0;
      res_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      coarse_q      <= coarse_d;
      ph_start_q    <= ph_start_d;
      ph_stop_q     <= ph_stop_d;
      fine_a_q      <= fine_a_d;
      fine_b_q      <= fine_b_d;
      res_time_q    <= res_time_d;
      res_timeout_q <= res_timeout_d;
`ifdef TDC_BUBBLE_CHK_EN
      err_q         <= err_d;
      res_err_q     <= res_err_d;
`endif
    end
  end

  // Next-state and datapath updates for the measurement sequence.
  always_comb begin
    state_d       = state_q;
    coarse_d      = coarse_q;
    ph_start_d    = ph_start_q;
    ph_stop_d     = ph_stop_q;
    fine_a_d      = fine_a_q;
    fine_b_d      = fine_b_q;
    res_time_d    = res_time_q;
    res_timeout_d = res_timeout_q;
`ifdef TDC_BUBBLE_CHK_EN
    err_d         = err_q;
    res_err_d     = res_err_q;
`endif

    calc_s = $signed({1'b0, coarse_q, 5'b00000})
           + $signed({{(CNT_W + 1){1'b0}}, fine_b_q})
           - $signed({{(CNT_W + 1){1'b0}}, fine_a_q});

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_WAIT_START;
`ifdef TDC_BUBBLE_CHK_EN
          err_d   = 1'b0;
`endif
        end
      end

      // A stop coinciding with the start is not a measurement; ignore it.
      S_WAIT_START: begin
        if (start_hit) begin
          ph_start_d = phase;
          coarse_d   = '0;
          state_d    = S_RUN;
        end
      end

      // The counter freezes on stop so coarse_q keeps the stop-cycle value.
      // A stop in the timeout cycle still produces a real measurement.
      S_RUN: begin
        if (stop_hit) begin
          ph_stop_d = phase;
          state_d   = S_DEC_A;
        end else if (coarse_q == TIMEOUT_C) begin
          res_time_d    = RES_ALL_ONES;
          res_timeout_d = 1'b1;
`ifdef TDC_BUBBLE_CHK_EN
          res_err_d     = 1'b0;
`endif
          state_d       = S_DONE;
        end else begin
          coarse_d = coarse_q + CNT_W'(1);
        end
      end

      S_DEC_A: begin
        fine_a_d = dec_out;
`ifdef TDC_BUBBLE_CHK_EN
        if (!dec_legal) err_d = 1'b1;
`endif
        state_d  = S_DEC_B;
      end

      S_DEC_B: begin
        fine_b_d = dec_out;
`ifdef TDC_BUBBLE_CHK_EN
        if (!dec_legal) err_d = 1'b1;
`endif
        state_d  = S_CALC;
      end

      // Negative interval only arises at coarse=0 with fine_b<fine_a: clamp.
      S_CALC: begin
        res_timeout_d = 1'b0;
        if (calc_s[CNT_W+5]) begin
          res_time_d = '0;
        end else begin
          res_time_d = calc_s[CNT_W+4:0];
        end
`ifdef TDC_BUBBLE_CHK_EN
        res_err_d = err_q;
        if (err_q) res_time_d = '0;
`endif
        state_d = S_DONE;
      end

      // Result held until accepted; all requests and hits are ignored here.
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign res_time    = res_time_q;
  assign res_timeout = res_timeout_q;
`ifdef TDC_BUBBLE_CHK_EN
  assign res_err     = res_err_q;
`else
  assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Testbench for tdc_meas_ctrl: directed boundary measurements plus
// randomized measurements checked against a transaction-level model.
// The thermometer decoder is modelled here as a lookup over all 32
// legal rotations of a 16-one run.
module tb_tdc_meas_ctrl;
  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 4095;

  logic             clk = 1'b0;
  logic             rst;
  logic             arm;
  logic             start_hit;
  logic             stop_hit;
  logic [31:0]      phase;
  logic [31:0]      dec_in;
  logic [4:0]       dec_out;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W+4:0] res_time;
  logic             res_timeout;
  logic             res_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdc_meas_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .arm(arm), .start_hit(start_hit), .stop_hit(stop_hit),
    .phase(phase), .dec_in(dec_in), .dec_out(dec_out), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_time(res_time),
    .res_timeout(res_timeout), .res_err(res_err)
  );

  function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
    if (r == 0) return v;
    return (v << r) | (v >> (32 - r));
  endfunction

  // Fine code of a vector: the run of ones starting at bit r gives (16-r)
  // mod 32; anything that is not such a run returns -1.
  function automatic int fine_of(input logic [31:0] v);
    for (int r = 0; r < 32; r++) begin
      if (v == rotl(32'h0000FFFF, r)) return (16 - r + 32) % 32;
    end
    return -1;
  endfunction

  assign dec_out = (fine_of(dec_in) < 0) ? 5'd0 : 5'(fine_of(dec_in));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result for a stop at coarse value k (k<0 means no stop).
  task automatic model(input logic [31:0] ps, input logic [31:0] pe, input int k,
                       output int t, output bit to, output bit er);
    int fa, fb;
    bit bad;
    if (k < 0) begin
      t = (1 << (CNT_W + 5)) - 1; to = 1'b1; er = 1'b0;
      return;
    end
    fa = fine_of(ps); fb = fine_of(pe);
    bad = (fa < 0) || (fb < 0);
    if (fa < 0) fa = 0;
    if (fb < 0) fb = 0;
    t = k * 32 + fb - fa;
    if (t < 0) t = 0;
    to = 1'b0;
    er = 1'b0;
`ifdef TDC_BUBBLE_CHK_EN
    if (bad) begin er = 1'b1; t = 0; end
`endif
  endtask

  task automatic run_meas(input logic [31:0] ps, input logic [31:0] pe, input int k, input int hold);
    int t, lat, cnt;
    bit to, er, dec_nz;
    model(ps, pe, k, t, to, er);
    // Hits while idle are ignored.
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      start_hit = 1'($urandom_range(0, 1)); stop_hit = 1'($urandom_range(0, 1));
      phase = $urandom; tick();
      check_val("idle_busy", 32'(busy), 32'd0);
    end
    start_hit = 1'b0; stop_hit = 1'b0; arm = 1'b1; tick(); arm = 1'b0;
    check_val("armed_busy", 32'(busy), 32'd1);
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      stop_hit = 1'($urandom_range(0, 1)); phase = $urandom; tick();
    end
    start_hit = 1'b1; stop_hit = 1'($urandom_range(0, 1)); phase = ps; tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    if (k < 0) begin
      cnt = 0; dec_nz = 1'b0;
      while (!res_valid && cnt < 5000) begin
        start_hit = 1'($urandom_range(0, 1)); phase = $urandom; tick(); cnt++;
        if (dec_in != 32'h0) dec_nz = 1'b1;
      end
      start_hit = 1'b0;
      check_val("timeout_cycles", 32'(cnt), 32'd4096);
      check_val("timeout_dec_idle", 32'(dec_nz), 32'd0);
    end else begin
      for (int i = 0; i < k; i++) begin
        start_hit = 1'($urandom_range(0, 1)); phase = $urandom; tick();
      end
      start_hit = 1'b0; stop_hit = 1'b1; phase = pe; tick();
      stop_hit = 1'b0; phase = $urandom; lat = 1;
      check_val("dec_a_in", dec_in, ps);
      tick(); lat++;
      check_val("dec_b_in", dec_in, pe);
      while (!res_valid && lat < 12) begin tick(); lat++; end
      check_val("latency", 32'(lat), 32'd4);
    end
    check_val("res_valid", 32'(res_valid), 32'd1);
    check_val("res_time", 32'(res_time), 32'(t));
    check_val("res_timeout", 32'(res_timeout), 32'(to));
    check_val("res_err", 32'(res_err), 32'(er));
    $display("meas k=%0d ps=%h pe=%h -> time=%0d to=%0d err=%0d", k, ps, pe, res_time, res_timeout, res_err);
    // Backpressure: result must stay put while requests are thrown at it.
    for (int i = 0; i < hold; i++) begin
      arm = 1'($urandom_range(0, 1)); start_hit = 1'($urandom_range(0, 1));
      stop_hit = 1'($urandom_range(0, 1)); phase = $urandom; tick();
      check_val("hold_valid", 32'(res_valid), 32'd1);
      check_val("hold_busy", 32'(busy), 32'd1);
      check_val("hold_time", 32'(res_time), 32'(t));
      check_val("hold_to_err", {30'd0, res_timeout, res_err}, {30'd0, to, er});
    end
    // Handshake with a simultaneous arm, which must be ignored.
    arm = 1'b1; start_hit = 1'b0; stop_hit = 1'b0; res_ready = 1'b1; tick();
    arm = 1'b0; res_ready = 1'b0;
    check_val("ack_busy", 32'(busy), 32'd0);
    check_val("ack_valid", 32'(res_valid), 32'd0);
    check_val("ack_time_kept", 32'(res_time), 32'(t));
    tick();
    check_val("ack_arm_ignored", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_valid"}, 32'(res_valid), 32'd0);
    check_val({tag, "_time"}, 32'(res_time), 32'd0);
    check_val({tag, "_to_err"}, {30'd0, res_timeout, res_err}, 32'd0);
    check_val({tag, "_dec_in"}, dec_in, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ps, pe;
    rst = 1'b1; arm = 1'b0; start_hit = 1'b0; stop_hit = 1'b0;
    phase = 32'h0; res_ready = 1'b0;
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;

    run_meas(32'hFFFF0000, 32'h0000FFFF, 9, 20);     // nominal: 304
    run_meas(32'h0FFFF000, 32'hFFFF0000, 0, 2);      // clamp to 0
    run_meas(32'h00FFFF00, 32'h000FFFF0, TIMEOUT, 1); // stop in timeout cycle
    run_meas(32'hFFFF0000, 32'h0000FFFF, -1, 3);     // no stop
    run_meas(32'hFFFF0000, 32'hFFFF0001, 5, 1);      // illegal stop vector
    run_meas(32'h0000FFFF, 32'hFFFF0000, 3, 0);      // clean run after an error

    // Reset in the middle of RUN at coarse=50.
    arm = 1'b1; tick(); arm = 1'b0;
    start_hit = 1'b1; phase = 32'hFFFF0000; tick(); start_hit = 1'b0;
    for (int i = 0; i < 50; i++) begin phase = $urandom; tick(); end
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero("midrun_reset");
    run_meas(32'hFFFF0000, 32'h0000FFFF, 9, 0);

    for (int n = 0; n < 25; n++) begin
      ps = rotl(32'h0000FFFF, int'($urandom_range(0, 31)));
      pe = rotl(32'h0000FFFF, int'($urandom_range(0, 31)));
      if ($urandom_range(0, 5) == 0) pe = $urandom;
      if ($urandom_range(0, 7) == 0) ps = ps ^ (32'h1 << $urandom_range(0, 31));
      run_meas(ps, pe, int'($urandom_range(0, 80)), int'($urandom_range(0, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
